// File: rtl/ad_trig_capture.sv
// Triggered pre/post capture of ADC samples into a circular RAM, streamed out oldest-first.
// Define AD_CAP_AUTOTRIG_EN to force a trigger after AUTO_TIMEOUT untriggered WAIT_TRIG samples.
module ad_trig_capture #(
    parameter int DW           = 8,
    parameter int DEPTH        = 256,
    parameter int AUTO_TIMEOUT = 4096,
    parameter int AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_en,
    input  logic [DW-1:0] ad_data,
    input  logic          ad_otr,
    input  logic          arm,
    input  logic          abort,
    input  logic [DW-1:0] trig_level,
    input  logic [AW-1:0] trig_pre,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          busy,
    output logic          done,
    output logic          otr_seen,
    output logic          auto_trig
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_TRIG,
        POST,
        READ
    } state_t;

    localparam logic [AW-1:0] AW_ONE   = AW'(1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] pre_len;
    logic [AW-1:0] cnt;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_cnt;
    logic [DW-1:0] prev;
    logic          prev_valid;
    logic [1:0]    rd_phase;

    logic          capturing;
    logic          wr_en;
    logic          real_trig;
    logic          auto_hit;
    logic          trig_hit;
    logic          rd_fire;
    logic [AW-1:0] post_len;

    assign capturing = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
    assign wr_en     = capturing && sample_en && !abort;
    assign real_trig = prev_valid && (prev < trig_level) && (ad_data >= trig_level);
    assign trig_hit  = real_trig || auto_hit;
    // DEPTH-1-pre_len is just the bitwise complement because DEPTH is a power of two.
    assign post_len  = ~pre_len;
    assign rd_fire   = rd_valid && rd_ready;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= ad_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            pre_len    <= '0;
            cnt        <= '0;
            trig_addr  <= '0;
            rd_ptr     <= '0;
            rd_cnt     <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            rd_phase   <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_last    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            otr_seen   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr_en) begin
                wr_ptr     <= wr_ptr + AW_ONE;
                prev       <= ad_data;
                prev_valid <= 1'b1;
                otr_seen   <= otr_seen | ad_otr;
            end
            if (abort) begin
                state    <= IDLE;
                busy     <= 1'b0;
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            pre_len    <= trig_pre;
                            cnt        <= '0;
                            prev_valid <= 1'b0;
                            otr_seen   <= 1'b0;
                            rd_phase   <= '0;
                            busy       <= 1'b1;
                            state      <= (trig_pre == '0) ? WAIT_TRIG : PRE;
                        end
                    end
                    PRE: begin
                        if (sample_en) begin
                            cnt <= cnt + AW_ONE;
                            if (cnt + AW_ONE == pre_len) begin
                                cnt   <= '0;
                                state <= WAIT_TRIG;
                            end
                        end
                    end
                    WAIT_TRIG: begin
                        if (sample_en && trig_hit) begin
                            trig_addr <= wr_ptr;
                            cnt       <= '0;
                            state     <= (post_len == '0) ? READ : POST;
                        end
                    end
                    POST: begin
                        if (sample_en) begin
                            cnt <= cnt + AW_ONE;
                            if (cnt + AW_ONE == post_len) begin
                                state <= READ;
                            end
                        end
                    end
                    READ: begin
                        // Phase 0 computes the window start, phase 1 primes the output
                        // register, then each transfer fetches the next word straight in.
                        case (rd_phase)
                            2'd0: begin
                                rd_ptr   <= trig_addr - pre_len;
                                rd_cnt   <= '0;
                                rd_phase <= 2'd1;
                            end
                            2'd1: begin
                                rd_data  <= mem[rd_ptr];
                                rd_valid <= 1'b1;
                                rd_last  <= 1'b0;
                                rd_phase <= 2'd2;
                            end
                            default: begin
                                if (rd_fire) begin
                                    if (rd_cnt == LAST_IDX) begin
                                        rd_valid <= 1'b0;
                                        rd_last  <= 1'b0;
                                        done     <= 1'b1;
                                        busy     <= 1'b0;
                                        rd_phase <= '0;
                                        state    <= IDLE;
                                    end else begin
                                        rd_cnt  <= rd_cnt + AW_ONE;
                                        rd_ptr  <= rd_ptr + AW_ONE;
                                        rd_data <= mem[rd_ptr + AW_ONE];
                                        rd_last <= (rd_cnt + AW_ONE == LAST_IDX);
                                    end
                                end
                            end
                        endcase
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef AD_CAP_AUTOTRIG_EN
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);

    logic [TW-1:0] to_cnt;

    assign auto_hit = (to_cnt == TW'(AUTO_TIMEOUT - 1));

    // A real trigger on the timeout sample wins, so auto_trig only marks pure timeouts.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt    <= '0;
            auto_trig <= 1'b0;
        end else if (!abort) begin
            if (state == IDLE && arm) begin
                to_cnt    <= '0;
                auto_trig <= 1'b0;
            end else if (state == WAIT_TRIG && sample_en) begin
                to_cnt <= to_cnt + TW'(1);
                if (!real_trig && auto_hit) begin
                    auto_trig <= 1'b1;
                end
            end
        end
    end
`else
    assign auto_hit  = 1'b0;
    assign auto_trig = 1'b0;
`endif

endmodule

// File: doc/ad_trig_capture.md
# ad_trig_capture

Triggered capture buffer for the high-speed ADC path. It consumes the 8-bit samples returned by the ADC at the `ad_clk` rate and stores a pre/post-trigger window in an internal circular RAM. After capture it streams the window out, oldest sample first, over a valid/ready interface. It sits directly downstream of the AD pins in the AD/DA loopback design and runs in the 100 MHz system domain, with sample qualification done by a strobe.

## Interface
- `DW`, 8: sample width.
- `DEPTH`, 256: capture window length in samples; power of two. `AW = $clog2(DEPTH)`.
- `AUTO_TIMEOUT`, 4096: auto-trigger timeout in samples. Used only with `AD_CAP_AUTOTRIG_EN`.

Ports:
- `clk` in 1: single clock (100 MHz).
- `rst` in 1: synchronous, active-high reset.
- `sample_en` in 1: one-cycle strobe; `ad_data`/`ad_otr` are valid on this cycle (1 of every 4 `clk` at 25 MHz ADC).
- `ad_data` in DW: ADC sample.
- `ad_otr` in 1: ADC out-of-range flag for the sample.
- `arm` in 1: start a capture; honoured only in IDLE.
- `abort` in 1: cancel capture or readout.
- `trig_level` in DW: rising-edge trigger threshold, unsigned.
- `trig_pre` in AW: number of pre-trigger samples; latched on arm.
- `rd_valid` out 1, `rd_ready` in 1, `rd_data` out DW, `rd_last` out 1: readout stream.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last word is transferred.
- `otr_seen` out 1: sticky; set if any stored sample had `ad_otr`=1.
- `auto_trig` out 1: the last trigger was forced by timeout.

## Operation
- States: IDLE → PRE → WAIT_TRIG → POST → READ → IDLE.
- **Arm accept** (IDLE, `arm`=1):
  - latch `pre = min(trig_pre, DEPTH-1)`;
  - clear `otr_seen`, `auto_trig`, the prev-valid flag and the sample counter;
  - go to PRE, or straight to WAIT_TRIG if `pre`=0.
- **Sample write.** In PRE, WAIT_TRIG and POST, each `sample_en` cycle does:
  - `mem[wr_ptr] <= ad_data`;
  - `wr_ptr` increments modulo DEPTH (wraps freely);
  - `prev <= ad_data`, prev-valid set;
  - `otr_seen |= ad_otr`.
- `sample_en` is ignored in IDLE and READ.
- **PRE.** Count written samples. When the count reaches `pre`, go to WAIT_TRIG. The trigger is not evaluated in PRE.
- **Trigger.** Evaluated in WAIT_TRIG on `sample_en` cycles: prev-valid && `prev < trig_level` && `ad_data >= trig_level`.
  - The triggering sample is written as usual.
  - Latch `trig_addr = wr_ptr` (address of the triggering sample).
  - Go to POST.
- **POST.** Write exactly `DEPTH-1-pre` further samples, then go to READ. If that count is 0, go to READ directly from the trigger cycle.
- **READ.**
  - Start address `start = trig_addr - pre` mod DEPTH.
  - Emit DEPTH words in address order with wrap.
  - `rd_last`=1 with word DEPTH-1 only.
- **Handshake.**
  - A transfer occurs on `rd_valid && rd_ready`.
  - While `rd_valid && !rd_ready`, `rd_data`/`rd_last` hold stable.
  - `rd_valid` never drops without a transfer, except on `abort`/`rst`.
- **Completion.** After the last transfer: `done`=1 for one cycle, `rd_valid`=0, state IDLE.
- **`abort`** in any state: next cycle IDLE, `rd_valid`=0, no `done`, RAM contents undefined. `abort` has priority over `arm` and the trigger.
- `arm` outside IDLE is ignored.
- Simultaneous `arm` and `sample_en` in IDLE: the sample is not stored.

## Timing
- Reset values: state IDLE; `busy`, `done`, `rd_valid`, `rd_last`, `otr_seen`, `auto_trig` = 0; `rd_data` = 0; `wr_ptr` = 0; prev-valid = 0.
- `busy` rises the cycle after arm accept and falls together with the `done` pulse.
- RAM is synchronous read (1-cycle).
- `rd_valid` rises 2 cycles after entering READ.
- Throughput: with `rd_ready` held high, one word per `clk` (prefetch/skid required). First transfer to `done` = DEPTH cycles.
- Trigger latency: the state changes on the `clk` after the triggering `sample_en`.

## Configuration
- `AD_CAP_AUTOTRIG_EN` defined:
  - WAIT_TRIG counts `sample_en` cycles.
  - On the `AUTO_TIMEOUT`-th sample without a trigger, that sample is treated as the trigger and `auto_trig` is set (sticky until next arm).
  - A real trigger on the same sample takes precedence; `auto_trig` stays 0.
- `AD_CAP_AUTOTRIG_EN` undefined: WAIT_TRIG waits indefinitely; `auto_trig` tied to 0; no timeout counter.

## Test plan
- **Basic ramp capture.** DEPTH=256, `trig_pre`=16, `trig_level`=0x80, ramp 0x00..0xFF repeating (1 sample/4 clk).
  - Expect 256 words; first = 0x70, word 16 = 0x80, last = 0x6F; `rd_last` only on word 255; one `done`.
- **Backpressure.** Toggle `rd_ready` randomly.
  - Expect no duplicate or lost words; `rd_data` stable while stalled.
  - With `rd_ready`=1 constant: 256 consecutive transfer cycles.
- **Boundary `trig_pre` values.**
  - `trig_pre`=0: first word = trigger sample 0x80.
  - `trig_pre`=255: last word = 0x80.
  - Flat input 0x80 followed by a ramp: no trigger until prev < 0x80.
- **Abort and reset mid-operation.**
  - `abort` in POST and mid-READ → IDLE next cycle, `rd_valid`=0, no `done`.
  - `rst` mid-READ → all outputs at reset values.
  - Re-arm and capture correctly.
- **Out-of-range flag and arm handling.**
  - `ad_otr`=1 on one stored sample → `otr_seen`=1 through readout, cleared on next arm.
  - `arm` pulsed during READ → ignored.
- **Auto-trigger** (`AD_CAP_AUTOTRIG_EN`, `AUTO_TIMEOUT`=4096).
  - Constant input 0x10 → trigger on the 4096th WAIT_TRIG sample, `auto_trig`=1, 256 words all 0x10.
